// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_unit_pkg;

  localparam int INST_W  = 32;
  localparam int JADDR_W = 26;

  localparam logic [INST_W-1:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_BRANCH,
    SEL_JUMP,
    SEL_HOLD
  } pc_sel_e;

  // Jump target keeps the 256 MB region of the instruction in decode.
  function automatic logic [31:0] jump_target(input logic [31:0]        pc_plus4,
                                              input logic [JADDR_W-1:0] jaddr);
    return {pc_plus4[31:28], jaddr, 2'b00};
  endfunction

  function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                input logic [31:0] word_offset);
    return pc_plus4 + (word_offset << 2);
  endfunction

endpackage

// File: rtl/fetch_unit_instr_mem.sv
// Run-time loadable instruction memory: synchronous write, combinational read,
// byte-addressed ports with out-of-range reads returning NOP.
module instr_mem
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [31:0]       waddr_i,
  input  logic [INST_W-1:0] wdata_i,
  input  logic [31:0]       raddr_i,
  output logic [INST_W-1:0] rdata_o
);

  localparam int AW = $clog2(DEPTH);

  logic [INST_W-1:0] mem_q [DEPTH];
  logic              w_in_range;
  logic              r_in_range;
  logic              unused_addr_bits;

  assign w_in_range       = (waddr_i[31:AW+2] == '0);
  assign r_in_range       = (raddr_i[31:AW+2] == '0);
  assign unused_addr_bits = ^{waddr_i[1:0], raddr_i[1:0]};

  // NOTE: the storage array has no reset; contents survive Reset and must be loaded before use.
  always_ff @(posedge clk) begin
    if (we_i && w_in_range) begin
      mem_q[waddr_i[AW+1:2]] <= wdata_i;
    end
  end

  assign rdata_o = r_in_range ? mem_q[raddr_i[AW+1:2]] : NOP;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, next-PC resolution from decode
// controls, loadable instruction memory and the IF/ID pipeline register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          IMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Branch,
  input  logic               Jump,
  input  logic               Stall,
  input  logic [31:0]        BranchOffset,
  input  logic [JADDR_W-1:0] JumpAddress,
  input  logic               LoadEn,
  input  logic [31:0]        LoadAddr,
  input  logic [INST_W-1:0]  LoadData,
  output logic [INST_W-1:0]  Inst,
  output logic [31:0]        PCPlus4,
  output logic               Valid
);

  logic [31:0]       pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [31:0]       pcplus4_q, pcplus4_d;
  logic              valid_q, valid_d;
  logic [INST_W-1:0] fetched;
  logic [31:0]       pc_seq;
  pc_sel_e           pc_sel;

  // A load to the word being fetched lands at the edge, so this cycle still sees the old word.
  instr_mem #(
    .DEPTH(IMEM_DEPTH)
  ) u_imem (
    .clk    (Clk),
    .we_i   (LoadEn),
    .waddr_i(LoadAddr),
    .wdata_i(LoadData),
    .raddr_i(pc_q),
    .rdata_o(fetched)
  );

  assign pc_seq = pc_q + 32'd4;

  // Stall outranks redirects: decode re-asserts Branch/Jump once the stall clears.
  always_comb begin
    if (Stall)       pc_sel = SEL_HOLD;
    else if (Jump)   pc_sel = SEL_JUMP;
    else if (Branch) pc_sel = SEL_BRANCH;
    else             pc_sel = SEL_SEQ;
  end

  // NOTE: every next-state signal gets a default before the case so no latch is inferred.
  always_comb begin
    pc_d      = pc_q;
    inst_d    = inst_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    unique case (pc_sel)
      SEL_SEQ: begin
        pc_d      = pc_seq;
        inst_d    = fetched;
        pcplus4_d = pc_seq;
        valid_d   = 1'b1;
      end
      SEL_JUMP: begin
        pc_d      = jump_target(pcplus4_q, JumpAddress);
        inst_d    = NOP;
        pcplus4_d = '0;
        valid_d   = 1'b0;
      end
      SEL_BRANCH: begin
        pc_d      = branch_target(pcplus4_q, BranchOffset);
        inst_d    = NOP;
        pcplus4_d = '0;
        valid_d   = 1'b0;
      end
      SEL_HOLD: ;
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q      <= RESET_PC;
      inst_q    <= NOP;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
    end
  end

  assign Inst    = inst_q;
  assign PCPlus4 = pcplus4_q;
  assign Valid   = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: driver feeds a behavioural model and queues
// expected IF/ID contents; a monitor pops and compares after every edge.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int          DEPTH     = 64;
  localparam logic [31:0] RST_PC    = 32'h0000_0000;
  localparam logic [31:0] MEM_BYTES = 4 * DEPTH;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] p4;
    logic        valid;
  } exp_t;

  logic               Clk = 1'b0;
  logic               Reset = 1'b1;
  logic               Branch = 1'b0;
  logic               Jump = 1'b0;
  logic               Stall = 1'b0;
  logic [31:0]        BranchOffset = '0;
  logic [JADDR_W-1:0] JumpAddress = '0;
  logic               LoadEn = 1'b0;
  logic [31:0]        LoadAddr = '0;
  logic [31:0]        LoadData = '0;
  logic [31:0]        Inst;
  logic [31:0]        PCPlus4;
  logic               Valid;

  fetch_unit #(
    .IMEM_DEPTH(DEPTH),
    .RESET_PC  (RST_PC)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Branch      (Branch),
    .Jump        (Jump),
    .Stall       (Stall),
    .BranchOffset(BranchOffset),
    .JumpAddress (JumpAddress),
    .LoadEn      (LoadEn),
    .LoadAddr    (LoadAddr),
    .LoadData    (LoadData),
    .Inst        (Inst),
    .PCPlus4     (PCPlus4),
    .Valid       (Valid)
  );

  always #5 Clk = ~Clk;

  // Reference model: memory as a plain word array, pipeline state as plain values.
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_p4;
  logic        m_valid;
  exp_t        exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_cycle  = 0;

  task automatic step(input bit rst, input bit br, input bit jp, input bit st,
                      input logic [31:0] boff, input logic [25:0] ja,
                      input bit le, input logic [31:0] la, input logic [31:0] ld);
    logic [31:0] fetched;
    @(negedge Clk);
    Reset = rst; Branch = br; Jump = jp; Stall = st;
    BranchOffset = boff; JumpAddress = ja;
    LoadEn = le; LoadAddr = la; LoadData = ld;

    fetched = (m_pc < MEM_BYTES) ? m_mem[m_pc / 4] : 32'h0;
    if (le && la < MEM_BYTES) m_mem[la / 4] = ld;
    if (rst) begin
      m_pc = RST_PC; m_inst = 0; m_p4 = 0; m_valid = 0;
    end else if (st) begin
      // everything holds
    end else if (jp || br) begin
      m_pc    = jp ? {m_p4[31:28], ja, 2'b00} : m_p4 + boff * 4;
      m_inst  = 0; m_p4 = 0; m_valid = 0;
    end else begin
      m_inst  = fetched;
      m_p4    = m_pc + 4;
      m_valid = 1;
      m_pc    = m_pc + 4;
    end
    exp_q.push_back('{inst: m_inst, p4: m_p4, valid: m_valid});
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_jump(input logic [25:0] ja);
    step(0, 0, 1, 0, 0, ja, 0, 0, 0);
  endtask

  task automatic do_branch(input logic [31:0] boff);
    step(0, 1, 0, 0, boff, 0, 0, 0, 0);
  endtask

  task automatic check(input string name, input exp_t got, input exp_t want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s @%0d: got inst=%h pcplus4=%h valid=%b, want inst=%h pcplus4=%h valid=%b",
               name, n_cycle, got.inst, got.p4, got.valid, want.inst, want.p4, want.valid);
    end
  endtask

  // Monitor: one expected entry per driven edge.
  initial begin
    exp_t want;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        check("ifid", '{inst: Inst, p4: PCPlus4, valid: Valid}, want);
        n_cycle++;
      end
    end
  end

  initial begin
    int guard;

    // Preload every word under Reset; low address bits are scrambled to show they are ignored.
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] d;
      d = (i < 4) ? 32'(i + 1) * 32'h11 : $urandom;
      step(1, 0, 0, 0, 0, 0, 1, 32'(i * 4) | 32'($urandom_range(0, 3)), d);
    end

    seq(4);                                  // 11,22,33,44 / 4,8,12,16
    step(0, 1, 1, 0, 32'h5, 26'h3, 0, 0, 0);   // Jump beats Branch: PC = 0x0C
    seq(2);                                  // mem[3], then mem[4]
    do_jump(26'h1);
    seq(1);                                  // PCPlus4 = 8
    do_branch(32'hFFFF_FFFE);                // back to 0
    seq(1);

    // Stall holds over Branch, then branch is taken once stall drops.
    step(0, 1, 0, 1, 32'h5, 0, 0, 0, 0);
    step(0, 1, 0, 1, 32'h5, 0, 0, 0, 0);
    step(0, 1, 0, 0, 32'h5, 0, 0, 0, 0);
    seq(1);

    guard = 0;
    while (m_pc != 32'h20 && guard < 40) begin seq(1); guard++; end
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    seq(2);

    // Load to the word being fetched: old word latched, new word on refetch.
    step(0, 0, 0, 0, 0, 0, 1, m_pc, 32'hDEAD_BEEF);
    do_jump(26'(m_p4 / 4 - 1));
    seq(2);
    step(0, 0, 0, 1, 0, 0, 1, 32'h8, 32'hCAFE_F00D);  // load accepted during stall
    step(0, 0, 0, 0, 0, 0, 1, 32'h100, 32'h1234_5678); // out-of-range load dropped
    do_jump(26'h2);
    seq(1);

    // Out-of-range fetch returns NOP with Valid = 1.
    do_jump(26'h40);
    seq(2);

    // PC wrap from the top of the address space back to 0.
    do_branch((32'hFFFF_FFF8 - m_p4) >> 2);
    seq(4);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      bit rst, br, jp, st, le;
      logic [31:0] boff, la;
      logic [25:0] ja;
      rst  = ($urandom_range(0, 39) == 0);
      st   = ($urandom_range(0, 5) == 0);
      br   = ($urandom_range(0, 5) == 0);
      jp   = ($urandom_range(0, 7) == 0);
      le   = ($urandom_range(0, 3) == 0);
      boff = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 40)) - 32'd20;
      ja   = ($urandom_range(0, 7) == 0) ? 26'($urandom) : 26'($urandom_range(0, 80));
      la   = 32'($urandom_range(0, 320));
      step(rst, br, jp, st, boff, ja, le, la, $urandom);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin @(posedge Clk); guard++; end
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
